// File: rtl/bist_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bist_pkg
//  Description : Shared types and default constants for the BIST scan
//                controller and its signature register.
//  Revision    : 1.0 - initial release
// ============================================================================
package bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SEED    = 3'd1,
        ST_SHIFT   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_UNLOAD  = 3'd4,
        ST_DONE    = 3'd5
    } bist_state_e;

    localparam int         DEF_CHAIN_LEN    = 8;
    localparam int         DEF_NUM_PATTERNS = 16;
    localparam int         DEF_SIG_WIDTH    = 8;
    // x^8 + x^4 + x^3 + x^2 + 1
    localparam logic [7:0] DEF_SIG_POLY     = 8'h1D;

endpackage : bist_pkg
`default_nettype wire

// File: rtl/bist_sisr.sv
`default_nettype none
// ============================================================================
//  Module      : bist_sisr
//  Description : Serial-input signature register compacting one response bit
//                per enabled cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module bist_sisr
    import bist_pkg::*;
#(
    parameter int                   SIG_WIDTH = DEF_SIG_WIDTH,
    parameter logic [SIG_WIDTH-1:0] SIG_POLY  = SIG_WIDTH'(DEF_SIG_POLY)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 enable,
    input  logic                 din,
    output logic [SIG_WIDTH-1:0] sig
);

    logic [SIG_WIDTH-1:0] sig_q;
    logic [SIG_WIDTH-1:0] sig_d;

    always_comb begin
        sig_d = sig_q;
        if (clear) begin
            sig_d = '0;
        end else if (enable) begin
            sig_d = {sig_q[SIG_WIDTH-2:0], 1'b0}
                  ^ (sig_q[SIG_WIDTH-1] ? SIG_POLY : '0)
                  ^ {{(SIG_WIDTH-1){1'b0}}, din};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule : bist_sisr
`default_nettype wire

// File: rtl/bist_scan_controller.sv
`default_nettype none
// ============================================================================
//  Module      : bist_scan_controller
//  Description : Test-per-scan BIST sequencer: seeds the LFSR, shifts and
//                captures NUM_PATTERNS chain loads, flushes the last response
//                and compacts unloaded bits into a SISR.
//                Optional macro BIST_GOLDEN_CHECK_EN adds the golden-signature
//                comparator driving `pass`.
//  Revision    : 1.0 - initial release
// ============================================================================
module bist_scan_controller
    import bist_pkg::*;
#(
    parameter int                   CHAIN_LEN    = DEF_CHAIN_LEN,
    parameter int                   NUM_PATTERNS = DEF_NUM_PATTERNS,
    parameter int                   SIG_WIDTH    = DEF_SIG_WIDTH,
    parameter logic [SIG_WIDTH-1:0] SIG_POLY     = SIG_WIDTH'(DEF_SIG_POLY),
    parameter logic [SIG_WIDTH-1:0] GOLDEN_SIG   = '0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 scan_out,
    output logic                 lfsr_reset,
    output logic                 scan_enable,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [SIG_WIDTH-1:0] signature
);

    localparam int              BIT_W    = $clog2(CHAIN_LEN);
    localparam int              PAT_W    = $clog2(NUM_PATTERNS + 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CHAIN_LEN - 1);
    localparam logic [PAT_W-1:0] PAT_END  = PAT_W'(NUM_PATTERNS);

    bist_state_e      state_q, state_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [PAT_W-1:0] pat_cnt_q, pat_cnt_d;
    logic [PAT_W-1:0] pat_inc;
    logic             sisr_clear;
    logic             sisr_enable;

    assign pat_inc = pat_cnt_q + PAT_W'(1);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        pat_cnt_d = pat_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_SEED;
            end
            ST_SEED: begin
                bit_cnt_d = '0;
                pat_cnt_d = '0;
                state_d   = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (bit_cnt_q == BIT_LAST) begin
                    bit_cnt_d = '0;
                    state_d   = ST_CAPTURE;
                end else begin
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                end
            end
            ST_CAPTURE: begin
                pat_cnt_d = pat_inc;
                state_d   = (pat_inc == PAT_END) ? ST_UNLOAD : ST_SHIFT;
            end
            ST_UNLOAD: begin
                if (bit_cnt_q == BIT_LAST) begin
                    bit_cnt_d = '0;
                    state_d   = ST_DONE;
                end else begin
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                end
            end
            ST_DONE: begin
                if (start) state_d = ST_SEED;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            pat_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            pat_cnt_q <= pat_cnt_d;
        end
    end

    // Pattern 0's shift unloads power-on chain content, so it is not compacted.
    assign sisr_clear  = (state_q == ST_SEED);
    assign sisr_enable = ((state_q == ST_SHIFT) && (pat_cnt_q != '0)) ||
                         (state_q == ST_UNLOAD);

    assign lfsr_reset  = (state_q == ST_IDLE) || (state_q == ST_SEED) ||
                         (state_q == ST_DONE);
    assign scan_enable = (state_q == ST_SHIFT) || (state_q == ST_UNLOAD);
    assign busy        = (state_q == ST_SEED)  || (state_q == ST_SHIFT) ||
                         (state_q == ST_CAPTURE) || (state_q == ST_UNLOAD);
    assign done        = (state_q == ST_DONE);

    bist_sisr #(
        .SIG_WIDTH (SIG_WIDTH),
        .SIG_POLY  (SIG_POLY)
    ) u_sisr (
        .clock  (clock),
        .reset  (reset),
        .clear  (sisr_clear),
        .enable (sisr_enable),
        .din    (scan_out),
        .sig    (signature)
    );

`ifdef BIST_GOLDEN_CHECK_EN
    assign pass = done && (signature == GOLDEN_SIG);
`else
    logic unused_golden;
    assign unused_golden = ^GOLDEN_SIG;
    assign pass          = 1'b0;
`endif

endmodule : bist_scan_controller
`default_nettype wire

// File: tb/tb_bist_scan_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bist_scan_controller
//  Description : Scoreboard bench: each run pushes its expected outcome, a
//                monitor pops and compares on every rising edge of `done`.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bist_scan_controller;

    typedef struct {
        logic [7:0] sig;
        logic       pass;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic       scan_out;
    logic       lfsr_reset;
    logic       scan_enable;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] signature;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t exp_q[$];

    bist_scan_controller #(
        .CHAIN_LEN    (8),
        .NUM_PATTERNS (16),
        .SIG_WIDTH    (8),
        .SIG_POLY     (8'h1D),
        .GOLDEN_SIG   (8'h00)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .scan_out    (scan_out),
        .lfsr_reset  (lfsr_reset),
        .scan_enable (scan_enable),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .signature   (signature)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    endtask

    // Reference SISR with a constant input bit over n compaction cycles.
    function automatic logic [7:0] sisr_model(input logic din, input int n);
        logic [7:0] s = 8'h00;
        for (int i = 0; i < n; i++)
            s = {s[6:0], 1'b0} ^ (s[7] ? 8'h1D : 8'h00) ^ {7'b0, din};
        return s;
    endfunction

    function automatic logic exp_pass(input logic [7:0] sig);
`ifdef BIST_GOLDEN_CHECK_EN
        return (sig == 8'h00);
`else
        return 1'b0 & sig[0];
`endif
    endfunction

    // Monitor: counts per-run activity, compares at each new DONE.
    initial begin
        int   busy_c = 0, se_c = 0, cap_c = 0;
        logic done_prev = 1'b0;
        logic bad_pass  = 1'b0;
        exp_t e;
        forever begin
            @(negedge clock);
            if (reset) begin
                busy_c = 0; se_c = 0; cap_c = 0; done_prev = 1'b0; bad_pass = 1'b0;
            end else begin
                if (busy && lfsr_reset) begin
                    busy_c = 0; se_c = 0; cap_c = 0; bad_pass = 1'b0;
                end
                if (busy) busy_c++;
                if (scan_enable) se_c++;
                if (busy && !scan_enable && !lfsr_reset) cap_c++;
                if (!done && pass) bad_pass = 1'b1;
                if (done && !done_prev) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("signature", int'(signature), int'(e.sig));
                        check("pass", int'(pass), int'(e.pass));
                        check("busy_cycles", busy_c, 153);
                        check("scan_enable_cycles", se_c, 136);
                        check("capture_cycles", cap_c, 16);
                        check("pass_low_outside_done", int'(bad_pass), 0);
                    end
                end
                done_prev = done;
            end
        end
    end

    task automatic push_exp(input logic so);
        exp_t e;
        e.sig  = sisr_model(so, 128);
        e.pass = exp_pass(e.sig);
        exp_q.push_back(e);
    endtask

    task automatic pulse_start;
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 400) begin
            @(posedge clock); #1;
            n++;
        end
        if (!done) check(name, 0, 1);
    endtask

    task automatic wait_idle_check(input string name);
        @(negedge clock);
        check({name, "_busy"}, int'(busy), 0);
        check({name, "_lfsr_reset"}, int'(lfsr_reset), 1);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; scan_out = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_lfsr_reset", int'(lfsr_reset), 1);
        check("rst_scan_enable", int'(scan_enable), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_pass", int'(pass), 0);
        check("rst_signature", int'(signature), 0);
        reset = 1'b0;

        repeat (20) @(posedge clock);
        #1;
        check("idle_busy", int'(busy), 0);
        check("idle_done", int'(done), 0);
        check("idle_lfsr_reset", int'(lfsr_reset), 1);

        // Run 1: scan_out held 0; first SEED cycle checked directly.
        scan_out = 1'b0;
        push_exp(1'b0);
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        check("seed_busy", int'(busy), 1);
        check("seed_lfsr_reset", int'(lfsr_reset), 1);
        check("seed_scan_enable", int'(scan_enable), 0);
        wait_done("run0_timeout");
        repeat (2) @(posedge clock);
        #1;
        check("done_hold", int'(done), 1);

        // Run 2: scan_out held 1, with a stray start during SHIFT.
        scan_out = 1'b1;
        push_exp(1'b1);
        pulse_start();
        repeat (20) @(posedge clock);
        #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        wait_done("run1_timeout");

        // Mid-run reset at cycle 50, then a clean rerun.
        pulse_start();
        repeat (49) @(posedge clock);
        #1 reset = 1'b1;
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_signature", int'(signature), 0);
        check("midrst_done", int'(done), 0);
        @(posedge clock); #1 reset = 1'b0;
        wait_idle_check("midrst_idle");
        push_exp(1'b1);
        pulse_start();
        wait_done("rerun_timeout");

        // start held high in DONE restarts immediately.
        push_exp(1'b1);
        start = 1'b1;
        @(posedge clock); #1;
        check("restart_busy", int'(busy), 1);
        check("restart_done", int'(done), 0);
        start = 1'b0;
        wait_done("restart_timeout");
        repeat (3) @(posedge clock);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_bist_scan_controller
`default_nettype wire

// File: doc/bist_scan_controller.md
# bist_scan_controller

Test-per-scan BIST sequencer for the scan chain fed by the pseudo-random pattern LFSR.
- On `start`: seeds the LFSR, then for each pattern shifts a full chain load with `scan_enable` high and pulses one capture cycle.
- Flushes the last response and compacts every unloaded response bit into a serial-input signature register (SISR).
- Sits between the test access logic (start/done/pass) and the LFSR, scan chain and CUT.

## Interface
Parameters:
- `CHAIN_LEN`, 8, scan chain length in flops (≥2)
- `NUM_PATTERNS`, 16, patterns applied per run (≥1)
- `SIG_WIDTH`, 8, SISR width
- `SIG_POLY`, 8'h1D, SISR feedback tap mask (x^8+x^4+x^3+x^2+1)
- `GOLDEN_SIG`, 0, expected final signature

Ports:
- `clock`, in, 1, single system clock, rising edge
- `reset`, in, 1, asynchronous, active-high; returns all state to IDLE
- `start`, in, 1, run request, sampled only in IDLE or DONE
- `scan_out`, in, 1, serial output of scan chain
- `lfsr_reset`, out, 1, drives LFSR `reset` (LFSR reset is synchronous)
- `scan_enable`, out, 1, 1 = shift, 0 = capture/functional
- `busy`, out, 1, high in SEED/SHIFT/CAPTURE/UNLOAD
- `done`, out, 1, high in DONE
- `pass`, out, 1, signature == GOLDEN_SIG (see Configuration)
- `signature`, out, SIG_WIDTH, SISR contents

## Operation
- States: IDLE, SEED, SHIFT, CAPTURE, UNLOAD, DONE.
- IDLE: `lfsr_reset`=1, `scan_enable`=0. `start`=1 → SEED.
- SEED: 1 cycle, `lfsr_reset`=1, SISR cleared, `pat_cnt`=0, `bit_cnt`=0 → SHIFT.
- SHIFT: `scan_enable`=1, `lfsr_reset`=0. The LFSR free-runs from here on, CAPTURE cycles included; the sequence is deterministic from SEED.
  - Runs CHAIN_LEN cycles; `bit_cnt` counts 0..CHAIN_LEN-1.
  - At the last bit → CAPTURE.
- CAPTURE: 1 cycle, `scan_enable`=0, `pat_cnt` increments.
  - If new `pat_cnt` == NUM_PATTERNS → UNLOAD, else → SHIFT.
- UNLOAD: CHAIN_LEN cycles, `scan_enable`=1, flushes the final response → DONE.
- DONE: `done`=1, `lfsr_reset`=1. Holds `signature` and `pass` until `start` (→ SEED, full rerun) or `reset`.
- Compaction enable is true in SHIFT when `pat_cnt` > 0, and in every UNLOAD cycle. Pattern 0's shift unloads power-on chain content and is not compacted.
- SISR update when enabled: sig ← {sig[W-2:0],0} ^ (sig[W-1] ? SIG_POLY : 0) ^ {0…0, scan_out}. Otherwise sig holds.
- `start` while busy is ignored. `start` held high in DONE restarts immediately.

## Timing
- Reset values: state IDLE, `lfsr_reset`=1, `scan_enable`=0, `busy`=0, `done`=0, `pass`=0, `signature`=0, counters 0.
- All outputs are registered or decoded from state; no combinational path from `start` or `scan_out` to any output.
- `start` high at edge N → SEED during cycle N+1 (`busy`=1).
- Run length from SEED to the first DONE cycle: 1 + NUM_PATTERNS·(CHAIN_LEN+1) + CHAIN_LEN cycles. Defaults: 153.
- `scan_enable` high cycles: NUM_PATTERNS·CHAIN_LEN + CHAIN_LEN. Compaction cycles: (NUM_PATTERNS-1)·CHAIN_LEN + CHAIN_LEN.
- `pass` is valid from the first DONE cycle and is 0 in all other states.
- Reset mid-run: asynchronous return to IDLE; `signature` is cleared and no partial result is retained.
- Counter widths: `bit_cnt` $clog2(CHAIN_LEN), `pat_cnt` $clog2(NUM_PATTERNS+1); no wrap is reachable.

## Configuration
- `BIST_GOLDEN_CHECK_EN` defined: comparator instantiated; in DONE, `pass` = (`signature` == GOLDEN_SIG).
- Not defined: no comparator, `pass` tied 0; software reads `signature` only. `GOLDEN_SIG` is unused.

## Structure
- Shared package `bist_pkg`: state enum typedef, default SISR polynomial constant, default CHAIN_LEN and NUM_PATTERNS constants.
- One sub-module, `bist_sisr`: SIG_WIDTH serial-input signature register with `clear`, `enable`, `din`, `sig` ports, parameterised by SIG_POLY.
- FSM and counters stay in the top module.

## Test plan
- Reset/idle: assert `reset` → all outputs at reset values, `lfsr_reset`=1. Hold `start`=0 for 20 cycles → no state change.
- Cycle count (defaults): pulse `start` → `busy`=1 for exactly 153 cycles, 136 `scan_enable` cycles, 16 single-cycle CAPTURE lows, then `done`=1.
- Signature, `scan_out`=0: full run → `signature`=0x00. With macro and GOLDEN_SIG=0 → `pass`=1.
- Signature, `scan_out`=1: full run → `signature` equals the bench reference model over 128 compaction cycles. With macro and GOLDEN_SIG≠model → `pass`=0. Without macro → `pass`=0 always.
- Mid-run reset: assert `reset` at cycle 50 of a run → immediate IDLE with `signature`=0. Rerun → identical signature to an uninterrupted run.
- Start handling: pulse `start` during SHIFT → ignored, run length unchanged. `start` held high in DONE → SEED next cycle, `done` drops, second signature equals the first.
